// File: rtl/imem_loader.sv
// Boot-time program loader: takes a length byte followed by little-endian
// instruction bytes and writes the assembled 32-bit words to instruction memory.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  word_count,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on the state register, so the source may hold
    // in_valid for as long as it likes without losing or duplicating a byte.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    state_t      state, state_next;
    logic [7:0]  len;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    logic        accept;
    logic [7:0]  count_inc;

    assign accept    = in_valid && in_ready;
    assign count_inc = word_count + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dbg_state  = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_LIM)
                        state_next = S_DONE;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && byte_idx == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_en      = 1'b1;
                busy       = 1'b1;
                state_next = (count_inc == len) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bytes shift in from the top so byte 0 ends up in the low lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len        <= 8'd0;
            byte_idx   <= 2'd0;
            shift      <= 24'd0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            err        <= 1'b0;
            word_count <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    err        <= 1'b0;
                    word_count <= 8'd0;
                    byte_idx   <= 2'd0;
                    shift      <= 24'd0;
                end
                S_LEN: begin
                    if (accept) begin
                        len      <= in_data;
                        byte_idx <= 2'd0;
                        if ({1'b0, in_data} > DEPTH_LIM) err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_data <= {in_data, shift};
                            wr_addr <= 32'(word_count);
                        end else begin
                            shift <= {in_data, shift[23:8]};
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= count_inc;
                    byte_idx   <= 2'd0;
                end
                S_DONE: begin
                    if (start) begin
                        err        <= 1'b0;
                        word_count <= 8'd0;
                        byte_idx   <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte driver, write scoreboard keyed on {addr,data},
// and directed length/reset/restart scenarios.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  word_count;
    logic [2:0]  dbg_state;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_errors;
    int          n_writes;
    logic [31:0] last_addr;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest expected word
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            check("in_ready_in_write", 64'(in_ready), 64'd0);
            check("addr_range", 64'(wr_addr < DEPTH), 64'd1);
            if (exp_q.size() == 0)
                check("unexpected_write", {wr_addr, wr_data}, 64'hffff_ffff_ffff_ffff);
            else
                check("write", {wr_addr, wr_data}, exp_q.pop_front());
            n_writes++;
            last_addr = wr_addr;
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_flags", {59'd0, in_ready, wr_en, busy, done, err}, 64'd0);
        check("rst_addr_data", {wr_addr, wr_data}, 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input int gap);
        send_byte(data[7:0],   gap);
        send_byte(data[15:8],  gap);
        send_byte(data[23:16], gap);
        exp_q.push_back({addr, data});
        send_byte(data[31:24], gap);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_end(input string tag, input int wc, input int writes, input logic e);
        check({tag, "_flags"}, {61'd0, done, busy, err}, {61'd0, 1'b1, 1'b0, e});
        check({tag, "_count"}, 64'(word_count), 64'(wc));
        check({tag, "_writes"}, 64'(n_writes), 64'(writes));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        logic [31:0] w;
        n_checks = 0;
        n_errors = 0;
        n_writes = 0;
        last_addr = '0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(negedge clk);
        do_reset();

        // basic load, in_valid back-to-back
        base = n_writes;
        pulse_start();
        send_byte(8'h02, 0);
        send_word(32'd0, 32'h0010_0093, 0);
        send_word(32'd1, 32'h0020_0113, 0);
        wait_done();
        check_end("basic", 2, base + 2, 1'b0);

        // stalled source, 3 idle cycles between bytes
        base = n_writes;
        pulse_start();
        check("restart_clears", {62'd0, done, 1'b0} | 64'(word_count), 64'd0);
        send_byte(8'h02, 3);
        send_word(32'd0, 32'h0010_0093, 3);
        send_word(32'd1, 32'h0020_0113, 3);
        wait_done();
        check_end("stall", 2, base + 2, 1'b0);

        // length 0: done on the next cycle, nothing written
        base = n_writes;
        pulse_start();
        send_byte(8'h00, 0);
        check_end("len0", 0, base, 1'b0);

        // length DEPTH+1: error, nothing written
        base = n_writes;
        pulse_start();
        send_byte(8'h41, 0);
        check_end("len_over", 0, base, 1'b1);

        // length DEPTH: full memory, last write at DEPTH-1
        base = n_writes;
        pulse_start();
        check("err_cleared", 64'(err), 64'd0);
        send_byte(8'h40, 0);
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            send_word(32'(i), w, $urandom_range(0, 1));
        end
        wait_done();
        check_end("full", DEPTH, base + DEPTH, 1'b0);
        check("full_last_addr", 64'(last_addr), 64'(DEPTH - 1));

        // reset in the middle of a word discards the partial bytes
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        base = n_writes;
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'd0, 32'hDEAD_BEEF, 0);
        wait_done();
        check_end("after_rst", 1, base + 1, 1'b0);

        // start ignored while loading; restart from DONE writes from addr 0
        base = n_writes;
        pulse_start();
        send_byte(8'h03, 0);
        send_word(32'd0, 32'h1111_2222, 0);
        send_byte(8'h44, 1);
        pulse_start();
        check("ign_start_busy", {62'd0, busy, done}, 64'd2);
        check("ign_start_count", 64'(word_count), 64'd1);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        exp_q.push_back({32'd1, 32'h1122_3344});
        send_byte(8'h11, 0);
        pulse_start();
        send_word(32'd2, 32'h5566_7788, 0);
        wait_done();
        check_end("ign_start", 3, base + 3, 1'b0);

        base = n_writes;
        pulse_start();
        check("restart_state", {61'd0, done, busy, in_ready}, 64'd3);
        check("restart_count", 64'(word_count), 64'd0);
        send_byte(8'h01, 0);
        send_word(32'd0, 32'hCAFE_F00D, 0);
        wait_done();
        check_end("restart", 1, base + 1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
